// File: rtl/serial_compare_if.sv
// Operand/result handshake bundle for serial_compare_ctrl.
// The master side is the producer/consumer. The slave side is the comparator.
interface serial_compare_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             aeb;
  logic             agb;
  logic             alb;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, aeb, agb, alb
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, aeb, agb, alb
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit per clock.
// Optional macro SERIAL_COMPARE_EARLY_EXIT_EN ends the scan at the first differing bit.
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_compare_if.slave  io_cmp
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_decided;
  logic             r_a_gt;
  logic             r_aeb;
  logic             r_agb;
  logic             r_alb;

  logic w_a_msb;
  logic w_b_msb;
  logic w_diff;
  logic w_gt;
  logic w_done;

  assign w_a_msb = r_a[WIDTH-1];
  assign w_b_msb = r_b[WIDTH-1];
  // Only the first differing bit counts; once decided, later bits are masked.
  assign w_diff  = !r_decided && (w_a_msb != w_b_msb);
  assign w_gt    = r_a_gt | (w_diff & w_a_msb);

`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
  assign w_done  = (r_cnt == '0) || w_diff;
`else
  assign w_done  = (r_cnt == '0);
`endif

  // NOTE: every register, including the operand shift paths, is cleared by the
  // async reset, so a reset mid-scan can never leak a stale partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_a_gt    <= 1'b0;
      r_aeb     <= 1'b0;
      r_agb     <= 1'b0;
      r_alb     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every branch reads pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (io_cmp.in_valid) begin
            r_a       <= io_cmp.a;
            r_b       <= io_cmp.b;
            r_cnt     <= CW'(WIDTH - 1);
            r_decided <= 1'b0;
            r_a_gt    <= 1'b0;
            r_aeb     <= 1'b0;
            r_agb     <= 1'b0;
            r_alb     <= 1'b0;
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_a       <= r_a << 1;
          r_b       <= r_b << 1;
          r_cnt     <= r_cnt - CW'(1);
          r_decided <= r_decided | w_diff;
          r_a_gt    <= w_gt;
          if (w_done) begin
            r_aeb   <= !(r_decided || w_diff);
            r_agb   <= w_gt;
            r_alb   <= (r_decided || w_diff) && !w_gt;
            r_state <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (io_cmp.out_ready) begin
            r_aeb   <= 1'b0;
            r_agb   <= 1'b0;
            r_alb   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_cmp.in_ready  = (r_state == S_IDLE);
  assign io_cmp.out_valid = (r_state == S_RESULT);
  assign io_cmp.aeb       = r_aeb;
  assign io_cmp.agb       = r_agb;
  assign io_cmp.alb       = r_alb;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl against an arithmetic reference model.
// Latency expectations follow SERIAL_COMPARE_EARLY_EXIT_EN when it is defined.
module tb_serial_compare_ctrl;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  serial_compare_if #(.WIDTH(W)) cif ();

  serial_compare_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_cmp (cif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] obs_flags;
  assign obs_flags = {cif.aeb, cif.agb, cif.alb};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_flags(input logic [W-1:0] x, input logic [W-1:0] y);
    return {x == y, x > y, x < y};
  endfunction

  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    logic [W-1:0] d;
    int k;
    d = x ^ y;
    if (d == '0) return W;
    k = 0;
    for (int i = 0; i < W; i++) if (d[i]) k = i;
    return W - k;
`else
    return W;
`endif
  endfunction

  // One full transaction: accept, scan, optional backpressure, handshake.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input int stall, input bit noise, output int rise_cyc);
    int lat;
    logic [2:0] exp_f;
    exp_f = model_flags(ta, tbv);
    @(negedge clk);
    check("idle_in_ready", cif.in_ready, 1);
    cif.in_valid  = 1'b1;
    cif.a         = ta;
    cif.b         = tbv;
    cif.out_ready = (stall == 0);
    @(posedge clk); #1;
    cif.in_valid = noise ? 1'($urandom) : 1'b0;
    cif.a        = W'($urandom);
    cif.b        = W'($urandom);
    lat = 0;
    while (!cif.out_valid && lat <= W + 2) begin
      check("scan_in_ready", cif.in_ready, 0);
      check("scan_flags", obs_flags, 0);
      @(posedge clk); #1;
      lat++;
    end
    rise_cyc = cyc;
    check("latency", lat, model_lat(ta, tbv));
    check("flags", obs_flags, exp_f);
    check("onehot", $countones(obs_flags), 1);
    for (int s = 0; s < stall; s++) begin
      cif.in_valid = 1'b1;
      cif.a        = W'($urandom);
      cif.b        = W'($urandom);
      @(posedge clk); #1;
      check("stall_valid", cif.out_valid, 1);
      check("stall_flags", obs_flags, exp_f);
      check("stall_in_ready", cif.in_ready, 0);
    end
    cif.out_ready = 1'b1;
    @(posedge clk); #1;
    cif.in_valid = 1'b0;
    check("post_valid", cif.out_valid, 0);
    check("post_in_ready", cif.in_ready, 1);
    check("post_flags", obs_flags, 0);
  endtask

  initial begin
    int r1, r2;
    logic [W-1:0] ra, rb;
    cif.in_valid  = 1'b0;
    cif.a         = '0;
    cif.b         = '0;
    cif.out_ready = 1'b0;
    #1;
    check("rst_in_ready", cif.in_ready, 1);
    check("rst_out_valid", cif.out_valid, 0);
    check("rst_flags", obs_flags, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_txn(8'h5A, 8'h5A, 0, 1'b0, r1);
    run_txn(8'h80, 8'h7F, 0, 1'b0, r1);
    run_txn(8'h12, 8'h13, 0, 1'b0, r1);
    run_txn(8'h03, 8'h01, 5, 1'b1, r1);

    // Reset three cycles into SCAN
    @(negedge clk);
    cif.in_valid  = 1'b1;
    cif.a         = 8'hF0;
    cif.b         = 8'h0F;
    cif.out_ready = 1'b0;
    @(posedge clk); #1;
    cif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", cif.in_ready, 1);
    check("midrst_out_valid", cif.out_valid, 0);
    check("midrst_flags", obs_flags, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_out_valid", cif.out_valid, 0);
    check("postrst_flags", obs_flags, 0);
    run_txn(8'h01, 8'h02, 0, 1'b0, r1);

    // Back-to-back with out_ready held high
    run_txn(8'hFF, 8'h00, 0, 1'b0, r1);
    run_txn(8'h00, 8'hFF, 0, 1'b0, r2);
    check("b2b_spacing", r2 - r1, model_lat(8'h00, 8'hFF) + 2);

    // Randomized pairs, including equal and extreme operands
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 4 == 0) rb = ra;
      if (i % 7 == 1) ra = '1;
      if (i % 5 == 2) rb = '0;
      run_txn(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), r1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
